// File: rtl/ups_pkg.sv
// Shared types and widths for the pressure-sensor monitor.
package ups_pkg;

    localparam int UPS_ADC_W = 12;

    typedef enum logic {
        NORMAL = 1'b0,
        ALARM  = 1'b1
    } ups_ps_state_t;

endpackage

// File: rtl/ups_ps_avg.sv
// Box-car averager: sums 2**AVG_LOG2 samples and publishes the truncated mean
// with a one-cycle valid pulse.
module ups_ps_avg
    import ups_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [UPS_ADC_W-1:0] in_data,
    input  logic                 in_dv,
    output logic [UPS_ADC_W-1:0] avg_data,
    output logic                 avg_dv
);

    localparam int ACC_W = UPS_ADC_W + AVG_LOG2;
    // A 1-bit counter that stays at 0 covers the pass-through case AVG_LOG2 = 0.
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]     acc_q, acc_d, sum;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [UPS_ADC_W-1:0] avg_q, avg_d;
    logic                 dv_q, dv_d;

    always_comb begin
        sum   = acc_q + ACC_W'(in_data);
        acc_d = acc_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        dv_d  = 1'b0;
        if (flush) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_dv) begin
            if (cnt_q == CNT_MAX) begin
                avg_d = UPS_ADC_W'(sum >> AVG_LOG2);
                dv_d  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
            dv_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
            dv_q  <= dv_d;
        end
    end

    assign avg_data = avg_q;
    assign avg_dv   = dv_q;

endmodule

// File: rtl/ups_ps_monitor.sv
// Pressure-sensor monitor: averaged samples feed a debounced hysteresis alarm,
// with a watchdog that flags a stalled sample stream.
module ups_ps_monitor
    import ups_pkg::*;
#(
    parameter int AVG_LOG2     = 4,
    parameter int DEBOUNCE     = 3,
    parameter int STALE_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [UPS_ADC_W-1:0] in_data,
    input  logic                 in_dv,
    input  logic [UPS_ADC_W-1:0] thr_hi,
    input  logic [UPS_ADC_W-1:0] thr_lo,
    output logic [UPS_ADC_W-1:0] avg_data,
    output logic                 avg_dv,
    output logic                 press_alarm,
    output logic                 stale
);

    localparam int SCNT_W = $clog2(STALE_CYCLES + 1);
    localparam int DBC_W  = $clog2(DEBOUNCE + 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STALE_CYCLES);
    localparam logic [DBC_W-1:0]  DBC_LAST = DBC_W'(DEBOUNCE - 1);

    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              stale_q, stale_d;
    logic [DBC_W-1:0]  dbc_q, dbc_d;
    ups_ps_state_t     state_q, state_d;
    logic              qual;

    // Partial averages are discarded on clr and on the edge that enters stale.
    ups_ps_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk      (clk),
        .rst      (rst),
        .flush    (clr | (stale_d & ~stale_q)),
        .in_data  (in_data),
        .in_dv    (in_dv),
        .avg_data (avg_data),
        .avg_dv   (avg_dv)
    );

    always_comb begin
        scnt_d = scnt_q;
        if (in_dv)                  scnt_d = '0;
        else if (scnt_q != SCNT_MAX) scnt_d = scnt_q + 1'b1;
        stale_d = (scnt_d == SCNT_MAX);
    end

    // Each state only tests its own exit condition, so overlapping thresholds are harmless.
    always_comb begin
        state_d = state_q;
        dbc_d   = dbc_q;
        qual    = (state_q == NORMAL) ? (avg_data >= thr_hi) : (avg_data <= thr_lo);
        if (clr) begin
            state_d = NORMAL;
            dbc_d   = '0;
        end else if (avg_dv) begin
            if (!qual) begin
                dbc_d = '0;
            end else if (dbc_q == DBC_LAST) begin
                state_d = (state_q == NORMAL) ? ALARM : NORMAL;
                dbc_d   = '0;
            end else begin
                dbc_d = dbc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q  <= '0;
            stale_q <= 1'b0;
            dbc_q   <= '0;
            state_q <= NORMAL;
        end else begin
            scnt_q  <= scnt_d;
            stale_q <= stale_d;
            dbc_q   <= dbc_d;
            state_q <= state_d;
        end
    end

    assign press_alarm = (state_q == ALARM);
    assign stale       = stale_q;

endmodule
